sram_1p_arb_ctrl: RTL and testbench
===================================

// Module: sram_1p_arb_ctrl
// PURPOSE
//  Shares one 144b x 32-word single-port SRAM (9-bit lanes, active-low CEN/GWEN/WEN) between one write and one read requester.
//  Fair round-robin arbitration, one access per cycle, translation to SRAM active-low strobes.
//  Automatic sleep (SLP) after a programmable idle period, with a fixed wake delay before grants resume.
//  Sits between the buffer-management logic and the SRAM wrapper.
// PARAMETERS
//  P_AW      5    SRAM address width (depth 1<<P_AW)
//  P_DW      144  data width; lanes = P_DW/9
//  P_IDLE    64   consecutive idle ACTIVE cycles before sleep; 0 = sleep disabled
//  P_WAKE    2    cycles SLP is held low before the first grant after wake (>=1)
// PORTS
//  CLK       in   1         clock
//  RST       in   1         synchronous reset, active-high
//  WR_REQ    in   1         write request; WR_ADDR/WR_DATA/WR_BE stable while high
//  WR_GNT    out  1         write accepted this cycle (combinational)
//  WR_ADDR   in   P_AW      write address
//  WR_DATA   in   P_DW      write data
//  WR_BE     in   P_DW/9    lane enables, active-high
//  RD_REQ    in   1         read request; RD_ADDR stable while high
//  RD_GNT    out  1         read accepted this cycle (combinational)
//  RD_ADDR   in   P_AW      read address
//  RD_VLD    out  1         RD_DATA valid (registered)
//  RD_DATA   out  P_DW      read data, = SRAM_Q
//  SRAM_CEN  out  1         to SRAM CEN, active-low
//  SRAM_GWEN out  1         to SRAM GWEN, active-low
//  SRAM_WEN  out  P_DW/9    to SRAM WEN, active-low = ~WR_BE
//  SRAM_A    out  P_AW      to SRAM A
//  SRAM_D    out  P_DW      to SRAM D = WR_DATA
//  SRAM_Q    in   P_DW      from SRAM Q
//  SRAM_SLP  out  1         to SRAM SLP (registered)
// BEHAVIOUR
//  Reset:
//   - state ACTIVE; idle counter 0; last-grant = WRITE, so the first tie goes to read.
//   - SRAM_SLP=0; RD_VLD=0.
//   - Combinational outputs are forced during reset: CEN=1, GWEN=1, WEN all-1, GNTs 0.
//   - Reset mid-read clears a pending RD_VLD.
//  Transfer: a transfer occurs when REQ & GNT; at most one GNT per cycle; GNTs are 0 outside ACTIVE.
//  Arbitration (ACTIVE):
//   - Only one requester: grant it.
//   - Both requesting: grant the one not granted last.
//   - last-grant updates only on a transfer.
//  Write in cycle N:
//   - CEN=0, GWEN=0, WEN=~WR_BE, A=WR_ADDR.
//   - The SRAM commits at the end of cycle N.
//   - WR_BE=0 still grants, and yields CEN=0, GWEN=0, WEN all-1 (no lane written).
//  Read in cycle N:
//   - CEN=0, GWEN=1, WEN all-1, A=RD_ADDR.
//   - RD_VLD=1 in N+1 with RD_DATA=SRAM_Q: latency 1, back-to-back every cycle.
//  No transfer: CEN=1, GWEN=1, WEN all-1; A/D hold don't-care (drive WR_ADDR/WR_DATA).
//  Write N then read same address N+1 returns the new data; no bypass is needed.
//  Sleep FSM:
//   ACTIVE
//    - Idle cycle (no REQ): count+1, saturating at P_IDLE.
//    - Any REQ: count=0.
//    - count reaches P_IDLE (P_IDLE>0): -> SLEEP; SRAM_SLP=1 from the next cycle.
//   SLEEP
//    - SLP=1, no grants.
//    - Any REQ: -> WAKE, SLP=0 next cycle, wake counter=0.
//   WAKE
//    - SLP=0, no grants; counter+1 per cycle.
//    - At P_WAKE cycles: -> ACTIVE, idle count=0; grants are allowed in that ACTIVE cycle.
//   Requests arriving in SLEEP/WAKE are held by the requester (no drop, no queue).
//  Grants are combinational from REQ and state; no combinational path SRAM_Q->GNT.
// TESTING
//  T1 reset:
//   - RST high 3 cycles with both REQ=1 -> GNTs 0, CEN=1, WEN=16'hFFFF, SLP=0, RD_VLD=0.
//  T2 write/read:
//   - Write A=5, D=144'h1234..., BE=16'hFFFF, then read A=5.
//   - Expect RD_VLD one cycle after RD_GNT with matching data.
//  T3 lane mask:
//   - Write A=7 all-ones, then write A=7 zeros with BE=16'h0001, then read.
//   - Expect only bits [8:0]=0, rest 1.
//  T4 tie:
//   - WR_REQ and RD_REQ held 6 cycles -> grants RD,WR,RD,WR,RD,WR.
//   - Exactly 3 RD_VLD pulses.
//  T5 sleep/wake with P_IDLE=4, P_WAKE=2:
//   - 4 idle cycles -> SLP=1.
//   - RD_REQ asserted -> SLP=0 next cycle; RD_GNT 2 cycles later; data correct.
//  T6 reset mid-op:
//   - RST asserted in the cycle after RD_GNT -> RD_VLD stays 0.
//   - Post-reset tie grants read first.

Source files
------------

// File: rtl/sram_1p_arb_ctrl.sv
// rtl/sram_1p_arb_ctrl.sv - write/read arbiter, strobe translator and sleep control for a 1-port SRAM
//
// Shares one single-port SRAM between a write requester and a read requester.
// Arbitration is round-robin on ties, with one access per cycle. Grants are translated
// into the SRAM's active-low CEN/GWEN/WEN strobes. After P_IDLE idle cycles the SRAM
// is put to sleep. A request wakes it, and grants resume after P_WAKE cycles.
//
// Ports:
//   CLK, RST                clock, synchronous active-high reset
//   WR_REQ/WR_GNT           write handshake; WR_ADDR/WR_DATA/WR_BE held while WR_REQ
//   RD_REQ/RD_GNT           read handshake; RD_ADDR held while RD_REQ
//   RD_VLD/RD_DATA          read return, one cycle after RD_GNT; RD_DATA = SRAM_Q
//   SRAM_CEN/GWEN/WEN       active-low SRAM strobes (WEN one bit per 9-bit lane)
//   SRAM_A/SRAM_D/SRAM_Q    SRAM address, write data, read data
//   SRAM_SLP                SRAM sleep, registered
module sram_1p_arb_ctrl #(
    parameter int P_AW   = 5,
    parameter int P_DW   = 144,
    parameter int P_IDLE = 64,
    parameter int P_WAKE = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WR_REQ,
    output logic                WR_GNT,
    input  logic [P_AW-1:0]     WR_ADDR,
    input  logic [P_DW-1:0]     WR_DATA,
    input  logic [P_DW/9-1:0]   WR_BE,
    input  logic                RD_REQ,
    output logic                RD_GNT,
    input  logic [P_AW-1:0]     RD_ADDR,
    output logic                RD_VLD,
    output logic [P_DW-1:0]     RD_DATA,
    output logic                SRAM_CEN,
    output logic                SRAM_GWEN,
    output logic [P_DW/9-1:0]   SRAM_WEN,
    output logic [P_AW-1:0]     SRAM_A,
    output logic [P_DW-1:0]     SRAM_D,
    input  logic [P_DW-1:0]     SRAM_Q,
    output logic                SRAM_SLP
);

    localparam int LANES = P_DW / 9;
    localparam int IW    = (P_IDLE > 0) ? $clog2(P_IDLE + 1) : 1;
    localparam int WW    = $clog2(P_WAKE + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(P_IDLE);
    localparam logic [WW-1:0] WAKE_LAST = WW'(P_WAKE - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WW-1:0]   wake_cnt_q, wake_cnt_d;
    logic            last_wr_q, last_wr_d;   // 1: most recent transfer was a write
    logic            rd_vld_q, rd_vld_d;
    logic            slp_q, slp_d;

    logic            any_req;
    logic            wr_gnt;
    logic            rd_gnt;

    assign any_req = WR_REQ | RD_REQ;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            last_wr_q  <= 1'b1;   // first tie after reset goes to the reader
            rd_vld_q   <= 1'b0;
            slp_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            last_wr_q  <= last_wr_d;
            rd_vld_q   <= rd_vld_d;
            slp_q      <= slp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;

        case (state_q)
            ST_ACTIVE: begin
                if (any_req) begin
                    idle_cnt_d = '0;
                end else if (P_IDLE > 0) begin
                    if (idle_cnt_q != IDLE_MAX) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                    // This idle cycle brings the count to P_IDLE: sleep from the next cycle.
                    if (idle_cnt_q == IDLE_MAX - 1'b1) begin
                        state_d = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: begin
                if (any_req) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                // SLP has been low for P_WAKE cycles once this cycle ends.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase

        last_wr_d = last_wr_q;
        if (wr_gnt) begin
            last_wr_d = 1'b1;
        end else if (rd_gnt) begin
            last_wr_d = 1'b0;
        end

        rd_vld_d = rd_gnt;
        slp_d    = (state_d == ST_SLEEP);
    end

    // Output logic: grants and SRAM strobes; everything idles while RST is high.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (!RST && state_q == ST_ACTIVE) begin
            if (WR_REQ && RD_REQ) begin
                if (last_wr_q) begin
                    rd_gnt = 1'b1;
                end else begin
                    wr_gnt = 1'b1;
                end
            end else begin
                wr_gnt = WR_REQ;
                rd_gnt = RD_REQ;
            end
        end

        WR_GNT    = wr_gnt;
        RD_GNT    = rd_gnt;
        SRAM_CEN  = ~(wr_gnt | rd_gnt);
        SRAM_GWEN = ~wr_gnt;
        SRAM_WEN  = wr_gnt ? ~WR_BE : {LANES{1'b1}};
        SRAM_A    = rd_gnt ? RD_ADDR : WR_ADDR;
        SRAM_D    = WR_DATA;
        // Reset landing in the cycle after a read grant suppresses its return.
        RD_VLD    = rd_vld_q & ~RST;
        RD_DATA   = SRAM_Q;
        SRAM_SLP  = slp_q;
    end

endmodule

// File: tb/tb_sram_1p_arb_ctrl.sv
// tb/tb_sram_1p_arb_ctrl.sv - directed bench with read-data scoreboard for sram_1p_arb_ctrl
module tb_sram_1p_arb_ctrl;

    localparam int AW = 5;
    localparam int DW = 144;
    localparam int NL = DW / 9;

    logic          clk;
    logic          rst;
    logic          wr_req, wr_gnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NL-1:0] wr_be;
    logic          rd_req, rd_gnt;
    logic [AW-1:0] rd_addr;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          sram_cen, sram_gwen;
    logic [NL-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;
    logic          sram_slp;

    sram_1p_arb_ctrl #(
        .P_AW  (AW),
        .P_DW  (DW),
        .P_IDLE(4),
        .P_WAKE(2)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .WR_REQ   (wr_req),
        .WR_GNT   (wr_gnt),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .WR_BE    (wr_be),
        .RD_REQ   (rd_req),
        .RD_GNT   (rd_gnt),
        .RD_ADDR  (rd_addr),
        .RD_VLD   (rd_vld),
        .RD_DATA  (rd_data),
        .SRAM_CEN (sram_cen),
        .SRAM_GWEN(sram_gwen),
        .SRAM_WEN (sram_wen),
        .SRAM_A   (sram_a),
        .SRAM_D   (sram_d),
        .SRAM_Q   (sram_q),
        .SRAM_SLP (sram_slp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM driven only from the strobe pins.
    logic [DW-1:0] sram_mem [0:31];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                for (int l = 0; l < NL; l++) begin
                    if (!sram_wen[l]) sram_mem[sram_a][l*9 +: 9] <= sram_d[l*9 +: 9];
                end
            end else begin
                sram_q <= sram_mem[sram_a];
            end
        end
    end

    // Reference memory updated from accepted write requests; expected read data queue.
    logic [DW-1:0] ref_mem [0:31];
    logic [DW-1:0] exp_q [$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic          s_wr_gnt, s_rd_gnt, s_cen, s_gwen, s_slp, s_vld;
    logic [NL-1:0] s_wen;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, run the scoreboard, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        s_wr_gnt = wr_gnt;
        s_rd_gnt = rd_gnt;
        s_cen    = sram_cen;
        s_gwen   = sram_gwen;
        s_wen    = sram_wen;
        s_a      = sram_a;
        s_slp    = sram_slp;
        s_vld    = rd_vld;
        s_data   = rd_data;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rd_vld) begin
                if (exp_q.size() == 0) chk("rd_vld_spurious", DW'(rd_vld), 0);
                else chk("rd_data", rd_data, exp_q.pop_front());
            end
            if (wr_req && rd_req) chk("gnt_excl", DW'(wr_gnt & rd_gnt), 0);
            if (rd_req && rd_gnt) exp_q.push_back(ref_mem[rd_addr]);
            if (wr_req && wr_gnt) begin
                for (int l = 0; l < NL; l++) begin
                    if (wr_be[l]) ref_mem[wr_addr][l*9 +: 9] = wr_data[l*9 +: 9];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
        logic got;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        wr_req  = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            step();
            got = s_wr_gnt;
        end
        if (!got) chk("wr_timeout", DW'(s_wr_gnt), 1);
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic got;
        rd_addr = a;
        rd_req  = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            step();
            got = s_rd_gnt;
        end
        if (!got) chk("rd_timeout", DW'(s_rd_gnt), 1);
        rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] exp3;
        int vld_cnt;

        d1   = 144'h1234_5678_9abc_def0_1122_3344_5566_7788_99aa;
        d2   = 144'hcafe_f00d_0bad_beef_0123_4567_89ab_cdef_5a5a;
        exp3 = ~144'h1ff;

        rst     = 1'b1;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '1;
        rd_addr = '0;

        // T1: reset with both requests high
        step();
        step();
        step();
        chk("t1_wr_gnt", DW'(s_wr_gnt), 0);
        chk("t1_rd_gnt", DW'(s_rd_gnt), 0);
        chk("t1_cen", DW'(s_cen), 1);
        chk("t1_gwen", DW'(s_gwen), 1);
        chk("t1_wen", DW'(s_wen), DW'(16'hffff));
        chk("t1_slp", DW'(s_slp), 0);
        chk("t1_vld", DW'(s_vld), 0);
        rst    = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;

        // T2: write then read back
        do_write(5'd5, d1, 16'hffff);
        chk("t2_wr_cen", DW'(s_cen), 0);
        chk("t2_wr_gwen", DW'(s_gwen), 0);
        chk("t2_wr_wen", DW'(s_wen), 0);
        chk("t2_wr_a", DW'(s_a), 5);
        do_read(5'd5);
        chk("t2_rd_cen", DW'(s_cen), 0);
        chk("t2_rd_gwen", DW'(s_gwen), 1);
        chk("t2_rd_wen", DW'(s_wen), DW'(16'hffff));
        chk("t2_rd_a", DW'(s_a), 5);
        step();
        chk("t2_vld", DW'(s_vld), 1);
        chk("t2_data", s_data, d1);

        // T3: lane mask, then a write with no lanes enabled
        do_write(5'd7, '1, 16'hffff);
        do_write(5'd7, '0, 16'h0001);
        chk("t3_wen_lane0", DW'(s_wen), DW'(16'hfffe));
        do_read(5'd7);
        step();
        chk("t3_vld", DW'(s_vld), 1);
        chk("t3_data", s_data, exp3);
        do_write(5'd7, '0, 16'h0000);
        chk("t3_be0_cen", DW'(s_cen), 0);
        chk("t3_be0_gwen", DW'(s_gwen), 0);
        chk("t3_be0_wen", DW'(s_wen), DW'(16'hffff));

        // T4: tie held for six cycles, last transfer was a write
        wr_addr = 5'd9;
        wr_data = d2;
        wr_be   = 16'hffff;
        rd_addr = 5'd7;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        vld_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_rd_gnt", DW'(s_rd_gnt), DW'(i % 2 == 0));
            chk("t4_wr_gnt", DW'(s_wr_gnt), DW'(i % 2 == 1));
            vld_cnt += int'(s_vld);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();
        vld_cnt += int'(s_vld);
        chk("t4_vld_pulses", DW'(vld_cnt), 3);

        // T5: the previous cycle was idle #1; three more idle cycles, then sleep
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_slp_low", DW'(s_slp), 0);
        end
        step();
        chk("t5_slp_high", DW'(s_slp), 1);
        rd_addr = 5'd5;
        rd_req  = 1'b1;
        step();
        chk("t5_sleep_slp", DW'(s_slp), 1);
        chk("t5_sleep_gnt", DW'(s_rd_gnt), 0);
        step();
        chk("t5_wake0_slp", DW'(s_slp), 0);
        chk("t5_wake0_gnt", DW'(s_rd_gnt), 0);
        step();
        chk("t5_wake1_slp", DW'(s_slp), 0);
        chk("t5_wake1_gnt", DW'(s_rd_gnt), 0);
        step();
        chk("t5_active_gnt", DW'(s_rd_gnt), 1);
        chk("t5_active_a", DW'(s_a), 5);
        rd_req = 1'b0;
        step();
        chk("t5_vld", DW'(s_vld), 1);
        chk("t5_data", s_data, d1);

        // T6: reset in the cycle after a read grant
        do_read(5'd5);
        rst = 1'b1;
        step();
        chk("t6_vld_rst", DW'(s_vld), 0);
        step();
        chk("t6_vld_rst2", DW'(s_vld), 0);
        rst     = 1'b0;
        wr_addr = 5'd11;
        wr_data = d2;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        step();
        chk("t6_vld_after", DW'(s_vld), 0);
        chk("t6_rd_first", DW'(s_rd_gnt), 1);
        chk("t6_wr_wait", DW'(s_wr_gnt), 0);
        step();
        chk("t6_wr_second", DW'(s_wr_gnt), 1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();
        step();
        chk("sb_empty", DW'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
